// File: rtl/mips_pkg.sv
// Shared decode constants, PC-control encoding and sequencer state for the MIPS branch control.
// Optional feature macro: MIPS_DELAY_SLOT_EN (branch delay slot handling).
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BLTZAL = 5'd16;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  localparam logic [4:0] LINK_RA = 5'd31;

  typedef enum logic [1:0] {
    PC_BRANCH = 2'b00,
    PC_JUMP   = 2'b01,
    PC_REG    = 2'b10,
    PC_INC    = 2'b11
  } pc_control_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DELAY  = 2'b01,
    ST_HALTED = 2'b10
  } branch_state_t;

  // Word offset of a conditional branch, sign-extended to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_branch_cond.sv
// Combinational decoder and signed condition evaluator for MIPS control transfers.
// Produces transfer/taken flags, the absolute target and the link destination.
module mips_branch_cond
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        is_transfer,
  output logic        taken,
  output logic [31:0] target,
  output logic        is_link,
  output logic [4:0]  link_reg
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rt_sel_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic        rs_neg_s;
  logic        rs_zero_s;

  assign opcode_s    = instr[31:26];
  assign funct_s     = instr[5:0];
  assign rt_sel_s    = instr[20:16];
  assign pc_plus4_s  = pc + 32'd4;
  assign br_target_s = pc_plus4_s + branch_offset(instr[15:0]);
  assign j_target_s  = {pc_plus4_s[31:28], instr[25:0], 2'b00};
  assign rs_neg_s    = rs_data[31];
  assign rs_zero_s   = (rs_data == 32'd0);

  // Decode the opcode class and evaluate the signed branch condition.
  always_comb begin
    is_transfer = 1'b0;
    taken       = 1'b0;
    target      = br_target_s;
    is_link     = 1'b0;
    link_reg    = LINK_RA;
    case (opcode_s)
      OP_BEQ:  begin is_transfer = 1'b1; taken = (rs_data == rt_data); end
      OP_BNE:  begin is_transfer = 1'b1; taken = (rs_data != rt_data); end
      OP_BLEZ: begin is_transfer = 1'b1; taken = rs_neg_s | rs_zero_s; end
      OP_BGTZ: begin is_transfer = 1'b1; taken = ~rs_neg_s & ~rs_zero_s; end
      OP_REGIMM: begin
        case (rt_sel_s)
          RT_BLTZ:   begin is_transfer = 1'b1; taken = rs_neg_s; end
          RT_BGEZ:   begin is_transfer = 1'b1; taken = ~rs_neg_s; end
          RT_BLTZAL: begin is_transfer = 1'b1; taken = rs_neg_s; is_link = 1'b1; end
          RT_BGEZAL: begin is_transfer = 1'b1; taken = ~rs_neg_s; is_link = 1'b1; end
          default:   begin is_transfer = 1'b0; end
        endcase
      end
      OP_J:   begin is_transfer = 1'b1; taken = 1'b1; target = j_target_s; end
      OP_JAL: begin is_transfer = 1'b1; taken = 1'b1; target = j_target_s; is_link = 1'b1; end
      OP_SPECIAL: begin
        case (funct_s)
          FN_JR:   begin is_transfer = 1'b1; taken = 1'b1; target = rs_data; end
          FN_JALR: begin
            is_transfer = 1'b1;
            taken       = 1'b1;
            target      = rs_data;
            is_link     = 1'b1;
            link_reg    = instr[15:11];
          end
          default: begin is_transfer = 1'b0; end
        endcase
      end
      default: begin is_transfer = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mips_branch_control.sv
// PC update sequencer with branch delay slot, link write and halt on a jump to address 0.
// Optional feature macro: MIPS_DELAY_SLOT_EN (undefined: transfers redirect on their own commit).
module mips_branch_control #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        CntEn,
  output logic [1:0]  PCControl,
  output logic [31:0] pc_next_data,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        active
);

  import mips_pkg::*;

  logic          transfer_s;
  logic          taken_s;
  logic [31:0]   target_s;
  logic          link_s;
  logic [4:0]    link_reg_s;
  logic          commit_s;
  pc_control_t   pc_ctrl_s;
  branch_state_t state_r;
  branch_state_t state_next_s;
  logic          unused_s;

  mips_branch_cond u_cond (
    .instr       (instr),
    .pc          (pc),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .is_transfer (transfer_s),
    .taken       (taken_s),
    .target      (target_s),
    .is_link     (link_s),
    .link_reg    (link_reg_s)
  );

  // Commits are ignored while reset is asserted.
  assign commit_s  = instr_valid & rst_n;
  assign PCControl = pc_ctrl_s;
  assign link_reg  = link_reg_s;
  assign link_data = pc + 32'd8;
  assign active    = (state_r != ST_HALTED);
  assign unused_s  = ^{RESET_VECTOR, transfer_s};

`ifdef MIPS_DELAY_SLOT_EN
  logic [31:0] pending_r;
  logic [31:0] pending_next_s;

  // State and pending-target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      pending_r <= 32'd0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Next state: a taken transfer parks its target until the delay slot commits.
  always_comb begin
    state_next_s   = state_r;
    pending_next_s = pending_r;
    case (state_r)
      ST_RUN: begin
        if (commit_s && taken_s) begin
          state_next_s   = ST_DELAY;
          pending_next_s = target_s;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DELAY: begin
        if (commit_s) begin
          state_next_s = (pending_r == 32'd0) ? ST_HALTED : ST_RUN;
        end else begin
          state_next_s = ST_DELAY;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // Outputs: the delay-slot commit performs the absolute load.
  always_comb begin
    CntEn        = 1'b0;
    link_we      = 1'b0;
    pc_ctrl_s    = PC_INC;
    pc_next_data = pending_r;
    case (state_r)
      ST_RUN: begin
        CntEn   = commit_s;
        link_we = commit_s & link_s;
      end
      ST_DELAY: begin
        CntEn     = commit_s;
        pc_ctrl_s = commit_s ? PC_REG : PC_INC;
      end
      default: CntEn = 1'b0;
    endcase
  end
`else
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a taken transfer to address 0 halts on its own commit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (commit_s && taken_s && (target_s == 32'd0)) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // Outputs: a taken transfer loads its target immediately.
  always_comb begin
    CntEn        = 1'b0;
    link_we      = 1'b0;
    pc_ctrl_s    = PC_INC;
    pc_next_data = 32'd0;
    case (state_r)
      ST_RUN: begin
        CntEn   = commit_s;
        link_we = commit_s & link_s;
        if (commit_s && taken_s) begin
          pc_ctrl_s    = PC_REG;
          pc_next_data = target_s;
        end else begin
          pc_ctrl_s    = PC_INC;
          pc_next_data = 32'd0;
        end
      end
      default: CntEn = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_mips_branch_control.sv
// Scoreboard bench for mips_branch_control; expectations follow the MIPS_DELAY_SLOT_EN build setting.
module tb_mips_branch_control;

`ifdef MIPS_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] JAL  = 32'h0C00_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr, pc, rs_data, rt_data;
  logic        CntEn;
  logic [1:0]  PCControl;
  logic [31:0] pc_next_data;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_data;
  logic        active;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [31:0] ins, p, rs, rt;
    logic        ce;
    logic [1:0]  pcc;
    logic [31:0] nxt;
    logic        lwe;
    logic [4:0]  lreg;
    logic [31:0] ldata;
    logic        act;
  } row_t;

  row_t sb[$];

  always #5 clk = ~clk;

  mips_branch_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .CntEn        (CntEn),
    .PCControl    (PCControl),
    .pc_next_data (pc_next_data),
    .link_we      (link_we),
    .link_reg     (link_reg),
    .link_data    (link_data),
    .active       (active)
  );

  function automatic row_t mk(input logic v, input logic [31:0] ins, p, rs, rt,
                              input logic ce, input logic [1:0] pcc, input logic [31:0] nxt,
                              input logic lwe, input logic [4:0] lreg, input logic [31:0] ldata,
                              input logic act);
    row_t r;
    r.v = v; r.ins = ins; r.p = p; r.rs = rs; r.rt = rt;
    r.ce = ce; r.pcc = pcc; r.nxt = nxt; r.lwe = lwe; r.lreg = lreg; r.ldata = ldata; r.act = act;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the edge, queue its expectation, move to the sample point.
  task automatic drive(input row_t r);
    @(posedge clk); #1;
    instr_valid = r.v; instr = r.ins; pc = r.p; rs_data = r.rs; rt_data = r.rt;
    sb.push_back(r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; instr = JAL; pc = 32'hBFC0_0000; rs_data = 32'd0; rt_data = 32'd0;
    @(negedge clk);
    checks++; if (CntEn !== 1'b0) begin failures++; $display("FAIL reset CntEn got=%b exp=0", CntEn); end
    checks++; if (link_we !== 1'b0) begin failures++; $display("FAIL reset link_we got=%b exp=0", link_we); end
    checks++; if (PCControl !== 2'b11) begin failures++; $display("FAIL reset PCControl got=%b exp=11", PCControl); end
    checks++; if (pc_next_data !== 32'd0) begin failures++; $display("FAIL reset pc_next_data got=%h exp=0", pc_next_data); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL reset active got=%b exp=1", active); end
    instr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_taken();
    row_t t[$]; row_t e;
    t.push_back(mk(1'b1, ADDU, 32'hBFC0_0000, 32'd1, 32'd2, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h1000_0003, 32'hBFC0_0010, 32'd5, 32'd5, 1'b1, DS ? 2'b11 : 2'b10, 32'hBFC0_0020, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'hBFC0_0014, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'hBFC0_0020, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h1400_FFFF, 32'h0000_0200, 32'd1, 32'd2, 1'b1, DS ? 2'b11 : 2'b10, 32'h0000_0200, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'h0000_0204, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'h0000_0200, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h1800_0001, 32'h0000_0300, 32'd0, 32'd0, 1'b1, DS ? 2'b11 : 2'b10, 32'h0000_0308, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'h0000_0304, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'h0000_0308, 1'b0, 5'd0, 32'd0, 1'b1));
    foreach (t[i]) begin
      drive(t[i]); e = sb.pop_front();
      checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL taken[%0d] CntEn got=%b exp=%b", i, CntEn, e.ce); end
      checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL taken[%0d] PCControl got=%b exp=%b", i, PCControl, e.pcc); end
      if (e.pcc == 2'b10) begin checks++; if (pc_next_data !== e.nxt) begin failures++; $display("FAIL taken[%0d] pc_next_data got=%h exp=%h", i, pc_next_data, e.nxt); end end
      checks++; if (link_we !== e.lwe) begin failures++; $display("FAIL taken[%0d] link_we got=%b exp=%b", i, link_we, e.lwe); end
      checks++; if (active !== e.act) begin failures++; $display("FAIL taken[%0d] active got=%b exp=%b", i, active, e.act); end
    end
  endtask

  task automatic test_untaken();
    row_t t[$]; row_t e;
    t.push_back(mk(1'b1, 32'h1400_0003, 32'h0000_0100, 32'd7, 32'd7, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h0400_0003, 32'h0000_0104, 32'd0, 32'd0, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h1C00_0003, 32'h0000_0108, 32'h8000_0000, 32'd0, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, ADDU, 32'h0000_010C, 32'd0, 32'd0, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    foreach (t[i]) begin
      drive(t[i]); e = sb.pop_front();
      checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL untaken[%0d] CntEn got=%b exp=%b", i, CntEn, e.ce); end
      checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL untaken[%0d] PCControl got=%b exp=%b", i, PCControl, e.pcc); end
      checks++; if (link_we !== e.lwe) begin failures++; $display("FAIL untaken[%0d] link_we got=%b exp=%b", i, link_we, e.lwe); end
      checks++; if (active !== e.act) begin failures++; $display("FAIL untaken[%0d] active got=%b exp=%b", i, active, e.act); end
    end
  endtask

  task automatic test_link();
    row_t t[$]; row_t e;
    t.push_back(mk(1'b1, JAL, 32'hBFC0_0000, 32'd0, 32'd0, 1'b1, DS ? 2'b11 : 2'b10, 32'hB000_0100, 1'b1, 5'd31, 32'hBFC0_0008, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'hBFC0_0004, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'hB000_0100, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h0080_2809, 32'h0040_0000, 32'h1234_5679, 32'd0, 1'b1, DS ? 2'b11 : 2'b10, 32'h1234_5679, 1'b1, 5'd5, 32'h0040_0008, 1'b1));
    t.push_back(mk(1'b1, DS ? JAL : NOP, 32'h0040_0004, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'h1234_5679, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, ADDU, 32'h0050_0000, 32'd0, 32'd0, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h0411_0002, 32'h0060_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 2'b11, 32'd0, 1'b1, 5'd31, 32'h0060_0008, 1'b1));
    t.push_back(mk(1'b1, JAL, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1, DS ? 2'b11 : 2'b10, 32'h0000_0100, 1'b1, 5'd31, 32'h0000_0004, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'h0000_0000, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'h0000_0100, 1'b0, 5'd0, 32'd0, 1'b1));
    foreach (t[i]) begin
      drive(t[i]); e = sb.pop_front();
      checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL link[%0d] CntEn got=%b exp=%b", i, CntEn, e.ce); end
      checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL link[%0d] PCControl got=%b exp=%b", i, PCControl, e.pcc); end
      if (e.pcc == 2'b10) begin checks++; if (pc_next_data !== e.nxt) begin failures++; $display("FAIL link[%0d] pc_next_data got=%h exp=%h", i, pc_next_data, e.nxt); end end
      checks++; if (link_we !== e.lwe) begin failures++; $display("FAIL link[%0d] link_we got=%b exp=%b", i, link_we, e.lwe); end
      if (e.lwe) begin checks++; if ({link_reg, link_data} !== {e.lreg, e.ldata}) begin failures++; $display("FAIL link[%0d] link_reg/data got=%0d/%h exp=%0d/%h", i, link_reg, link_data, e.lreg, e.ldata); end end
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$]; row_t e;
    t.push_back(mk(1'b1, 32'h1000_0003, 32'h0000_0400, 32'd9, 32'd9, 1'b1, DS ? 2'b11 : 2'b10, 32'h0000_0410, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b0, NOP, 32'h0000_0404, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b0, NOP, 32'h0000_0404, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, NOP, 32'h0000_0404, 32'd0, 32'd0, 1'b1, DS ? 2'b10 : 2'b11, 32'h0000_0410, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, 32'h1000_0003, 32'h0000_0500, 32'd9, 32'd9, 1'b1, DS ? 2'b11 : 2'b10, 32'h0000_0510, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b0, NOP, 32'h0000_0504, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b0, NOP, 32'h0000_0504, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    foreach (t[i]) begin
      drive(t[i]); e = sb.pop_front();
      checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL stall[%0d] CntEn got=%b exp=%b", i, CntEn, e.ce); end
      checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL stall[%0d] PCControl got=%b exp=%b", i, PCControl, e.pcc); end
      if (e.pcc == 2'b10) begin checks++; if (pc_next_data !== e.nxt) begin failures++; $display("FAIL stall[%0d] pc_next_data got=%h exp=%h", i, pc_next_data, e.nxt); end end
    end
    // Reset while the second branch is pending, with a commit presented.
    @(posedge clk); #1;
    rst_n = 1'b0; instr_valid = 1'b1; instr = NOP; pc = 32'h0000_0504;
    @(negedge clk);
    checks++; if (CntEn !== 1'b0) begin failures++; $display("FAIL midreset CntEn got=%b exp=0", CntEn); end
    checks++; if (PCControl !== 2'b11) begin failures++; $display("FAIL midreset PCControl got=%b exp=11", PCControl); end
    checks++; if (pc_next_data !== 32'd0) begin failures++; $display("FAIL midreset pc_next_data got=%h exp=0", pc_next_data); end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    drive(mk(1'b1, ADDU, RESET_VEC_TB(), 32'd0, 32'd0, 1'b1, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    e = sb.pop_front();
    checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL postreset PCControl got=%b exp=%b", PCControl, e.pcc); end
    checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL postreset CntEn got=%b exp=%b", CntEn, e.ce); end
  endtask

  function automatic logic [31:0] RESET_VEC_TB();
    return 32'hBFC0_0000;
  endfunction

  task automatic test_halt();
    row_t t[$]; row_t e;
    t.push_back(mk(1'b1, 32'h0000_0008, 32'h0000_1000, 32'd0, 32'd0, 1'b1, DS ? 2'b11 : 2'b10, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    if (DS) t.push_back(mk(1'b1, NOP, 32'h0000_1004, 32'd0, 32'd0, 1'b1, 2'b10, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
    t.push_back(mk(1'b1, JAL, 32'h0000_0000, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
    t.push_back(mk(1'b1, ADDU, 32'h0000_0004, 32'd0, 32'd0, 1'b0, 2'b11, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
    foreach (t[i]) begin
      drive(t[i]); e = sb.pop_front();
      checks++; if (CntEn !== e.ce) begin failures++; $display("FAIL halt[%0d] CntEn got=%b exp=%b", i, CntEn, e.ce); end
      if (e.ce) begin checks++; if (PCControl !== e.pcc) begin failures++; $display("FAIL halt[%0d] PCControl got=%b exp=%b", i, PCControl, e.pcc); end end
      if (e.pcc == 2'b10) begin checks++; if (pc_next_data !== e.nxt) begin failures++; $display("FAIL halt[%0d] pc_next_data got=%h exp=%h", i, pc_next_data, e.nxt); end end
      checks++; if (link_we !== e.lwe) begin failures++; $display("FAIL halt[%0d] link_we got=%b exp=%b", i, link_we, e.lwe); end
      checks++; if (active !== e.act) begin failures++; $display("FAIL halt[%0d] active got=%b exp=%b", i, active, e.act); end
    end
    // Only reset leaves the halted state.
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL halt_reset active got=%b exp=1", active); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_taken();
    test_untaken();
    test_link();
    test_back_to_back();
    test_halt();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
